ecc_22_wr_encode: RTL and testbench



---
 rtl/ecc_22_wr_encode.sv | 130 +++++++++++++
 tb/tb_ecc_22_wr_encode.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_22_wr_encode.sv
// Write-side SECDED encoder for the 22-bit ECC FIFO path: duplicated encoders with
// compare, one valid/ready register stage, and a one-shot data-corruption hook.
module ecc_22_wr_encode #(
  parameter int unsigned DATA_WIDTH   = 22,
  parameter int unsigned PARITY_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_vld,
  output logic                    wr_rdy,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    bypass,
  input  logic                    ecc_fault_detc_en,
  input  logic                    err_inj_sbit,
  input  logic                    err_inj_dbit,
  input  logic                    fault_clr,
  output logic                    mem_vld,
  input  logic                    mem_rdy,
  output logic [DATA_WIDTH-1:0]   mem_data,
  output logic [PARITY_WIDTH-1:0] mem_parity,
  output logic                    mem_fault,
  output logic                    fault_flag,
  output logic [7:0]              fault_cnt,
  output logic                    inj_armed
);

  // Codeword positions 1..27; powers of two hold Hamming bits, data fills the rest.
  function automatic logic [PARITY_WIDTH-1:0] ecc_encode(input logic [DATA_WIDTH-1:0] d);
    logic [PARITY_WIDTH-1:0] p;
    int k;
    p = '0;
    k = 0;
    for (int pos = 1; pos <= int'(DATA_WIDTH + PARITY_WIDTH - 1); pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        for (int i = 0; i < int'(PARITY_WIDTH - 1); i++) begin
          if (pos[i]) p[i] = p[i] ^ d[k];
        end
        k++;
      end
    end
    p[PARITY_WIDTH-1] = (^d) ^ (^p[PARITY_WIDTH-2:0]);
    return p;
  endfunction

  logic [PARITY_WIDTH-1:0] p0, p1;
  logic                    acc, mismatch;
  logic                    inj_dbit, inj_sbit;
  logic                    inj_dbit_q, inj_sbit_q;
  logic [DATA_WIDTH-1:0]   inj_mask;

  logic                    mem_vld_q;
  logic [DATA_WIDTH-1:0]   mem_data_q;
  logic [PARITY_WIDTH-1:0] mem_parity_q;
  logic                    mem_fault_q;
  logic                    fault_flag_q, fault_flag_d;
  logic [7:0]              fault_cnt_q, fault_cnt_d;

  // Two independent encoder instances in lock-step; p1 exists only for the compare.
  assign p0 = ecc_encode(wr_data);
  assign p1 = ecc_encode(wr_data);

  assign wr_rdy   = ~mem_vld_q | mem_rdy;
  assign acc      = wr_vld & wr_rdy;
  assign mismatch = (p0 != p1) & ecc_fault_detc_en & ~bypass;

  // An arm pulse coincident with an accepted beat applies to that beat.
  always_comb begin
    inj_dbit = inj_dbit_q | err_inj_dbit;
    inj_sbit = inj_sbit_q | err_inj_sbit;
    inj_mask = '0;
    if (inj_dbit) begin
      inj_mask = DATA_WIDTH'(3);
    end else if (inj_sbit) begin
      inj_mask = DATA_WIDTH'(1);
    end
  end

  always_comb begin
    fault_flag_d = fault_flag_q;
    fault_cnt_d  = fault_cnt_q;
    if (acc && mismatch) begin
      fault_flag_d = 1'b1;
      if (fault_clr) begin
        fault_cnt_d = 8'd1;
      end else if (fault_cnt_q != 8'hFF) begin
        fault_cnt_d = fault_cnt_q + 8'd1;
      end
    end else if (fault_clr) begin
      fault_flag_d = 1'b0;
      fault_cnt_d  = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_vld_q    <= 1'b0;
      mem_data_q   <= '0;
      mem_parity_q <= '0;
      mem_fault_q  <= 1'b0;
      inj_dbit_q   <= 1'b0;
      inj_sbit_q   <= 1'b0;
      fault_flag_q <= 1'b0;
      fault_cnt_q  <= 8'd0;
    end else begin
      fault_flag_q <= fault_flag_d;
      fault_cnt_q  <= fault_cnt_d;
      if (acc) begin
        mem_vld_q    <= 1'b1;
        mem_data_q   <= wr_data ^ inj_mask;
        mem_parity_q <= bypass ? '0 : p0;
        mem_fault_q  <= mismatch;
        inj_dbit_q   <= 1'b0;
        inj_sbit_q   <= 1'b0;
      end else begin
        if (mem_rdy) mem_vld_q <= 1'b0;
        inj_dbit_q <= inj_dbit;
        inj_sbit_q <= inj_sbit;
      end
    end
  end

  assign mem_vld    = mem_vld_q;
  assign mem_data   = mem_data_q;
  assign mem_parity = mem_parity_q;
  assign mem_fault  = mem_fault_q;
  assign fault_flag = fault_flag_q;
  assign fault_cnt  = fault_cnt_q;
  assign inj_armed  = inj_dbit_q | inj_sbit_q;

endmodule

// File: tb/tb_ecc_22_wr_encode.sv
// Directed bench for ecc_22_wr_encode: golden parity, streaming with backpressure,
// injection, redundant-encoder fault tracking and asynchronous reset.
module tb_ecc_22_wr_encode;

  logic        clk;
  logic        rst;
  logic        wr_vld;
  logic        wr_rdy;
  logic [21:0] wr_data;
  logic        bypass;
  logic        ecc_fault_detc_en;
  logic        err_inj_sbit;
  logic        err_inj_dbit;
  logic        fault_clr;
  logic        mem_vld;
  logic        mem_rdy;
  logic [21:0] mem_data;
  logic [5:0]  mem_parity;
  logic        mem_fault;
  logic        fault_flag;
  logic [7:0]  fault_cnt;
  logic        inj_armed;

  int checks = 0;
  int failures = 0;

  ecc_22_wr_encode #(
    .DATA_WIDTH  (22),
    .PARITY_WIDTH(6)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_vld           (wr_vld),
    .wr_rdy           (wr_rdy),
    .wr_data          (wr_data),
    .bypass           (bypass),
    .ecc_fault_detc_en(ecc_fault_detc_en),
    .err_inj_sbit     (err_inj_sbit),
    .err_inj_dbit     (err_inj_dbit),
    .fault_clr        (fault_clr),
    .mem_vld          (mem_vld),
    .mem_rdy          (mem_rdy),
    .mem_data         (mem_data),
    .mem_parity       (mem_parity),
    .mem_fault        (mem_fault),
    .fault_flag       (fault_flag),
    .fault_cnt        (fault_cnt),
    .inj_armed        (inj_armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference parity from hand-derived coverage masks of each Hamming bit.
  function automatic logic [5:0] ref_parity(input logic [21:0] d);
    logic [5:0] p;
    p[0] = ^(d & 22'h2AAD5B);
    p[1] = ^(d & 22'h33366D);
    p[2] = ^(d & 22'h03C78E);
    p[3] = ^(d & 22'h3C07F0);
    p[4] = ^(d & 22'h3FF800);
    p[5] = (^d) ^ (^p[4:0]);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({mem_vld, mem_fault, fault_flag, inj_armed} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000", {mem_vld, mem_fault, fault_flag, inj_armed});
    end
    checks++;
    if ({mem_data, mem_parity, fault_cnt} !== 36'h0) begin
      failures++;
      $display("FAIL reset_values: got data=%h par=%h cnt=%h expected all 0",
               mem_data, mem_parity, fault_cnt);
    end
    checks++;
    if (wr_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_wr_rdy: got %b expected 1", wr_rdy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_golden();
    logic [5:0] pexp;
    for (int i = 0; i < 3; i++) begin
      pexp = (i == 0) ? 6'h00 : (i == 1) ? 6'h23 : 6'h25;
      wr_vld  = 1'b1;
      wr_data = 22'(i);
      tick();
      wr_vld = 1'b0;
      checks++;
      if (mem_vld !== 1'b1 || mem_data !== 22'(i) || mem_parity !== pexp || mem_fault !== 1'b0)
      begin
        failures++;
        $display("FAIL golden_%0d: got vld=%b data=%h par=%h flt=%b expected 1 %h %h 0",
                 i, mem_vld, mem_data, mem_parity, mem_fault, 22'(i), pexp);
      end
    end
    tick();
    checks++;
    if (mem_vld !== 1'b0) begin
      failures++;
      $display("FAIL golden_drain: got mem_vld=%b expected 0", mem_vld);
    end
  endtask

  task automatic test_stream();
    logic [21:0] words[16];
    logic [21:0] q[$];
    logic [21:0] hd, exp_d;
    logic [5:0]  hp;
    logic        stalled;
    int          sent, recv;
    sent = 0;
    recv = 0;
    stalled = 1'b0;
    hd = '0;
    hp = '0;
    for (int i = 0; i < 16; i++) words[i] = 22'($urandom);
    for (int cyc = 0; cyc < 400 && recv < 16; cyc++) begin
      wr_vld  = (sent < 16);
      wr_data = (sent < 16) ? words[sent] : 22'h0;
      mem_rdy = 1'($urandom_range(0, 1));
      #1;
      if (stalled) begin
        checks++;
        if (mem_vld !== 1'b1 || mem_data !== hd || mem_parity !== hp) begin
          failures++;
          $display("FAIL stream_stall_hold: got vld=%b data=%h par=%h expected 1 %h %h",
                   mem_vld, mem_data, mem_parity, hd, hp);
        end
      end
      if (mem_vld === 1'b1 && mem_rdy) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL stream_dup: got extra word %h expected none", mem_data);
        end else begin
          exp_d = q.pop_front();
          if (mem_data !== exp_d || mem_parity !== ref_parity(exp_d)) begin
            failures++;
            $display("FAIL stream_word_%0d: got %h/%h expected %h/%h",
                     recv, mem_data, mem_parity, exp_d, ref_parity(exp_d));
          end
        end
        recv++;
      end
      stalled = (mem_vld === 1'b1) && !mem_rdy;
      hd = mem_data;
      hp = mem_parity;
      if (wr_vld && wr_rdy === 1'b1) begin
        q.push_back(words[sent]);
        sent++;
      end
      @(posedge clk);
      #1;
    end
    wr_vld  = 1'b0;
    mem_rdy = 1'b1;
    checks++;
    if (recv != 16 || sent != 16) begin
      failures++;
      $display("FAIL stream_count: got sent=%0d recv=%0d expected 16 16", sent, recv);
    end
    checks++;
    if (mem_vld !== 1'b0) begin
      failures++;
      $display("FAIL stream_drain: got mem_vld=%b expected 0", mem_vld);
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] w;
    mem_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = 22'($urandom);
      wr_vld  = 1'b1;
      wr_data = w;
      #1;
      checks++;
      if (wr_rdy !== 1'b1) begin
        failures++;
        $display("FAIL b2b_rdy_%0d: got %b expected 1", i, wr_rdy);
      end
      tick();
      checks++;
      if (mem_vld !== 1'b1 || mem_data !== w || mem_parity !== ref_parity(w)) begin
        failures++;
        $display("FAIL b2b_word_%0d: got vld=%b %h/%h expected 1 %h/%h",
                 i, mem_vld, mem_data, mem_parity, w, ref_parity(w));
      end
    end
    wr_vld = 1'b0;
    tick();
  endtask

  task automatic test_injection();
    mem_rdy = 1'b1;
    err_inj_sbit = 1'b1;
    tick();
    err_inj_sbit = 1'b0;
    checks++;
    if (inj_armed !== 1'b1) begin
      failures++;
      $display("FAIL inj_sbit_armed: got %b expected 1", inj_armed);
    end
    wr_vld = 1'b1; wr_data = 22'h000000;
    tick();
    wr_vld = 1'b0;
    checks++;
    if (mem_data !== 22'h000001 || mem_parity !== 6'h00 || inj_armed !== 1'b0) begin
      failures++;
      $display("FAIL inj_sbit: got %h/%h armed=%b expected 000001/00 armed=0",
               mem_data, mem_parity, inj_armed);
    end
    err_inj_sbit = 1'b1; err_inj_dbit = 1'b1;
    tick();
    err_inj_sbit = 1'b0; err_inj_dbit = 1'b0;
    wr_vld = 1'b1; wr_data = 22'h3FFFFF;
    tick();
    checks++;
    if (mem_data !== 22'h3FFFFC || mem_parity !== ref_parity(22'h3FFFFF)) begin
      failures++;
      $display("FAIL inj_dbit: got %h/%h expected 3ffffc/%h",
               mem_data, mem_parity, ref_parity(22'h3FFFFF));
    end
    wr_data = 22'h155555;
    tick();
    checks++;
    if (mem_data !== 22'h155555 || inj_armed !== 1'b0) begin
      failures++;
      $display("FAIL inj_next_clean: got %h armed=%b expected 155555 armed=0", mem_data, inj_armed);
    end
    err_inj_sbit = 1'b1; wr_data = 22'h0ABCDE;
    tick();
    err_inj_sbit = 1'b0;
    checks++;
    if (mem_data !== 22'h0ABCDF || inj_armed !== 1'b0) begin
      failures++;
      $display("FAIL inj_same_cycle: got %h armed=%b expected 0abcdf armed=0", mem_data, inj_armed);
    end
    mem_rdy = 1'b0; err_inj_dbit = 1'b1; wr_data = 22'h200010;
    tick();
    err_inj_dbit = 1'b0;
    checks++;
    if (inj_armed !== 1'b1 || mem_data !== 22'h0ABCDF) begin
      failures++;
      $display("FAIL inj_stall_hold: got %h armed=%b expected 0abcdf armed=1", mem_data, inj_armed);
    end
    mem_rdy = 1'b1;
    tick();
    wr_vld = 1'b0;
    checks++;
    if (mem_data !== 22'h200013 || inj_armed !== 1'b0) begin
      failures++;
      $display("FAIL inj_after_stall: got %h armed=%b expected 200013 armed=0", mem_data, inj_armed);
    end
    tick();
  endtask

  task automatic test_fault();
    mem_rdy = 1'b1; ecc_fault_detc_en = 1'b1; bypass = 1'b0;
    force dut.p1 = 6'h01;
    wr_vld = 1'b1; wr_data = 22'h0;
    tick();
    checks++;
    if (mem_fault !== 1'b1 || fault_flag !== 1'b1 || fault_cnt !== 8'd1) begin
      failures++;
      $display("FAIL fault_en: got flt=%b flag=%b cnt=%0d expected 1 1 1",
               mem_fault, fault_flag, fault_cnt);
    end
    ecc_fault_detc_en = 1'b0;
    tick();
    checks++;
    if (mem_fault !== 1'b0 || fault_cnt !== 8'd1) begin
      failures++;
      $display("FAIL fault_dis: got flt=%b cnt=%0d expected 0 1", mem_fault, fault_cnt);
    end
    ecc_fault_detc_en = 1'b1; bypass = 1'b1;
    tick();
    checks++;
    if (mem_fault !== 1'b0 || mem_parity !== 6'h00 || fault_cnt !== 8'd1) begin
      failures++;
      $display("FAIL fault_bypass: got flt=%b par=%h cnt=%0d expected 0 00 1",
               mem_fault, mem_parity, fault_cnt);
    end
    bypass = 1'b0; wr_vld = 1'b0; fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if (fault_flag !== 1'b0 || fault_cnt !== 8'd0) begin
      failures++;
      $display("FAIL fault_clr_first: got flag=%b cnt=%0d expected 0 0", fault_flag, fault_cnt);
    end
    wr_vld = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 253) begin
        checks++;
        if (fault_cnt !== 8'hFE) begin
          failures++;
          $display("FAIL fault_cnt_254: got %h expected fe", fault_cnt);
        end
      end
    end
    wr_vld = 1'b0;
    checks++;
    if (fault_cnt !== 8'hFF || fault_flag !== 1'b1) begin
      failures++;
      $display("FAIL fault_saturate: got cnt=%h flag=%b expected ff 1", fault_cnt, fault_flag);
    end
    wr_vld = 1'b1; fault_clr = 1'b1;
    tick();
    wr_vld = 1'b0;
    checks++;
    if (fault_flag !== 1'b1 || fault_cnt !== 8'd1) begin
      failures++;
      $display("FAIL fault_clr_collide: got flag=%b cnt=%0d expected 1 1", fault_flag, fault_cnt);
    end
    tick();
    fault_clr = 1'b0;
    checks++;
    if (fault_flag !== 1'b0 || fault_cnt !== 8'd0) begin
      failures++;
      $display("FAIL fault_clr_alone: got flag=%b cnt=%0d expected 0 0", fault_flag, fault_cnt);
    end
    release dut.p1;
    tick();
  endtask

  task automatic test_reset_mid();
    mem_rdy = 1'b0;
    wr_vld = 1'b1; wr_data = 22'h2AAAAA;
    tick();
    wr_vld = 1'b0; err_inj_sbit = 1'b1;
    tick();
    err_inj_sbit = 1'b0;
    checks++;
    if (mem_vld !== 1'b1 || inj_armed !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_setup: got vld=%b armed=%b expected 1 1", mem_vld, inj_armed);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_vld, mem_fault, fault_flag, inj_armed} !== 4'b0000 ||
        {mem_data, mem_parity, fault_cnt} !== 36'h0) begin
      failures++;
      $display("FAIL rst_mid_async: got vld=%b data=%h par=%h armed=%b expected all 0",
               mem_vld, mem_data, mem_parity, inj_armed);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; mem_rdy = 1'b1;
    tick();
    wr_vld = 1'b1; wr_data = 22'h000000;
    tick();
    wr_vld = 1'b0;
    checks++;
    if (mem_vld !== 1'b1 || mem_data !== 22'h000000 || mem_parity !== 6'h00) begin
      failures++;
      $display("FAIL rst_mid_clean: got vld=%b %h/%h expected 1 000000/00",
               mem_vld, mem_data, mem_parity);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    wr_vld = 1'b0;
    wr_data = '0;
    bypass = 1'b0;
    ecc_fault_detc_en = 1'b1;
    err_inj_sbit = 1'b0;
    err_inj_dbit = 1'b0;
    fault_clr = 1'b0;
    mem_rdy = 1'b1;
    #2;
    test_reset();
    test_golden();
    test_stream();
    test_back_to_back();
    test_injection();
    test_fault();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
